// File: rtl/lsu_vam.sv
// lsu_vam: load/store unit between the core memory stage and the
// variable-access-mode data memory. One request at a time; aligned
// accesses take a single memory cycle, misaligned ones are split into
// little-endian byte accesses. Load data is sign/zero-extended on return.
module lsu_vam (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  mem_accessmode,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_WORD = 2'b10;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  cnt_inc;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] buf_nxt;
  logic        mis_q;
  logic        mem_we_q;
  logic        req_fire;
  logic        req_ill;
  logic        req_mis;
  logic        acc_last;

  // Illegal codes: 011, 110, 111, and the unsigned-load codes used as stores.
  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  // Size code 00 = byte (never misaligned), 01 = half, 10 = word.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (sz)
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Index of the final byte of a split access (size-1).
  function automatic logic [1:0] last_byte(input logic [1:0] sz);
    logic [1:0] l;
    case (sz)
      2'b00:   l = 2'd0;
      2'b01:   l = 2'd1;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  // Sign- or zero-extend the assembled load value according to funct3.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'd0, d[7:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign req_fire = req_valid && req_ready;
  assign req_ill  = illegal_f3(req_we, req_funct3);
  assign req_mis  = misaligned(req_funct3[1:0], req_addr[1:0]);
  assign cnt_inc  = cnt + 2'd1;
  assign acc_last = !mis_q || (cnt == last_byte(f3_q[1:0]));

  // Write enable is dropped as soon as reset is seen, so an aborted split
  // store keeps only the bytes committed at earlier edges.
  assign mem_we = mem_we_q && !reset;

  // Load buffer update for the current ACC cycle: whole word when aligned,
  // otherwise the byte lane selected by cnt.
  always_comb begin
    buf_nxt = buf_q;
    if (state == ACC && !we_q) begin
      if (!mis_q) begin
        buf_nxt = mem_rd;
      end else begin
        case (cnt)
          2'd0:    buf_nxt[7:0]   = mem_rd[7:0];
          2'd1:    buf_nxt[15:8]  = mem_rd[7:0];
          2'd2:    buf_nxt[23:16] = mem_rd[7:0];
          default: buf_nxt[31:24] = mem_rd[7:0];
        endcase
      end
    end
  end

  // Control FSM with registered request/response and memory-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      we_q           <= 1'b0;
      f3_q           <= 3'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      buf_q          <= 32'd0;
      mis_q          <= 1'b0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_err       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_accessmode <= MODE_WORD;
      mem_a          <= 32'd0;
      mem_wd         <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            mis_q     <= req_mis;
            cnt       <= 2'd0;
            buf_q     <= 32'd0;
            req_ready <= 1'b0;
            if (req_ill) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state          <= ACC;
              mem_we_q       <= req_we;
              mem_a          <= req_addr;
              mem_accessmode <= req_mis ? MODE_BYTE : req_funct3[1:0];
              mem_wd         <= req_mis ? {24'd0, req_wdata[7:0]} : req_wdata;
            end
          end
        end
        ACC: begin
          buf_q <= buf_nxt;
          if (acc_last) begin
            state          <= RESP;
            mem_we_q       <= 1'b0;
            mem_accessmode <= MODE_WORD;
            mem_a          <= 32'd0;
            mem_wd         <= 32'd0;
            resp_valid     <= 1'b1;
            resp_err       <= 1'b0;
            resp_rdata     <= we_q ? 32'd0 : extend_load(f3_q, buf_nxt);
          end else begin
            cnt    <= cnt_inc;
            mem_a  <= addr_q + {30'd0, cnt_inc};
            mem_wd <= {24'd0, byte_sel(wdata_q, cnt_inc)};
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_vam.sv
// tb_lsu_vam: bench for lsu_vam with a byte-array data memory, a
// request-level reference model producing the expected per-cycle bus and
// response trace, directed cases plus randomized requests.
module tb_lsu_vam;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  mem_accessmode;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_vam dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_accessmode(mem_accessmode), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data memory (256 bytes, address aliased by low 8 bits)
  logic [7:0] dmem [256];
  logic       clr;
  logic [7:0] b0, b1, b2, b3;

  assign b0 = dmem[mem_a[7:0]];
  assign b1 = dmem[mem_a[7:0] + 8'd1];
  assign b2 = dmem[mem_a[7:0] + 8'd2];
  assign b3 = dmem[mem_a[7:0] + 8'd3];
  assign mem_rd = (mem_accessmode == 2'b00) ? {24'd0, b0} :
                  (mem_accessmode == 2'b01) ? {16'd0, b1, b0} : {b3, b2, b1, b0};

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
    end else if (mem_we) begin
      case (mem_accessmode)
        2'b00: dmem[mem_a[7:0]] <= mem_wd[7:0];
        2'b01: begin
          dmem[mem_a[7:0]]        <= mem_wd[7:0];
          dmem[mem_a[7:0] + 8'd1] <= mem_wd[15:8];
        end
        default: begin
          dmem[mem_a[7:0]]        <= mem_wd[7:0];
          dmem[mem_a[7:0] + 8'd1] <= mem_wd[15:8];
          dmem[mem_a[7:0] + 8'd2] <= mem_wd[23:16];
          dmem[mem_a[7:0] + 8'd3] <= mem_wd[31:24];
        end
      endcase
    end
  end

  // ---------------- observation record and reference model state
  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic        err;
    logic [31:0] rd;
    logic        we;
    logic [1:0]  md;
    logic [31:0] a;
    logic [31:0] wd;
  } obs_t;

  localparam obs_t IDLE_OBS = {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 2'b10, 32'd0, 32'd0};

  obs_t        act_obs;
  obs_t        exp_obs;
  obs_t        exp_q[$];
  logic [7:0]  model_mem [256];
  logic        chk_en;
  logic [31:0] last_rdata;
  logic        last_err;
  int          n_checks;
  int          n_err;

  assign act_obs = {req_ready, resp_valid, resp_err, resp_rdata,
                    mem_we, mem_accessmode, mem_a, mem_wd};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Build the expected trace of one accepted request from the access rules
  // and apply its effect on the model memory.
  task automatic model_push(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
    obs_t        r;
    int          size;
    logic [31:0] v;
    logic [31:0] ak;
    bit          ill;
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    if (ill) begin
      r = IDLE_OBS; r.rdy = 1'b0; r.rv = 1'b1; r.err = 1'b1; r.rd = 32'd0;
      exp_q.push_back(r);
    end else begin
      size = 1 << f3[1:0];
      if ((addr % size) == 0) begin
        r = IDLE_OBS; r.rdy = 1'b0; r.we = we; r.md = f3[1:0]; r.a = addr; r.wd = wd;
        exp_q.push_back(r);
      end else begin
        for (int k = 0; k < size; k++) begin
          r = IDLE_OBS; r.rdy = 1'b0; r.we = we; r.md = 2'b00;
          r.a = addr + 32'(k);
          r.wd = (wd >> (8 * k)) & 32'hFF;
          exp_q.push_back(r);
        end
      end
      v = 32'd0;
      for (int k = 0; k < size; k++) begin
        ak = addr + 32'(k);
        if (we) model_mem[ak[7:0]] = 8'((wd >> (8 * k)) & 32'hFF);
        else    v = v | (32'(model_mem[ak[7:0]]) << (8 * k));
      end
      if (!f3[2] && size < 4 && (((v >> (8 * size - 1)) & 32'd1) != 0))
        v = v | (32'hFFFF_FFFF << (8 * size));
      r = IDLE_OBS; r.rdy = 1'b0; r.rv = 1'b1; r.err = 1'b0; r.rd = we ? 32'd0 : v;
      exp_q.push_back(r);
    end
  endtask

  // Per-cycle compare against the model trace (idle outputs when empty).
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() != 0) exp_obs = exp_q.pop_front();
        else                   exp_obs = IDLE_OBS;
        chk("cycle", 128'(act_obs), 128'(exp_obs));
        if (resp_valid) begin
          last_rdata = resp_rdata;
          last_err   = resp_err;
        end
      end
    end
  end

  // Issue one request; entered and left #1 after a posedge with DUT idle.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n;
    last_rdata = 32'hDEAD_BEEF;
    last_err   = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    model_push(we, f3, addr, wd);
    #1;
    req_valid  = 1'($urandom_range(0, 1));
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 20);
    if (exp_q.size() != 0) begin
      chk("req_timeout", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0; chk_en = 1'b0;
    last_rdata = 32'd0; last_err = 1'b0;
    reset = 1'b1; clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 128'(act_obs), 128'(IDLE_OBS));
    @(posedge clk); #1;
    reset = 1'b0; clr = 1'b0; chk_en = 1'b1;

    // aligned word load
    do_req(1'b1, 3'b010, 32'h10, 32'h8765_4321);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_aligned", 128'(last_rdata), 128'(32'h8765_4321));

    // signed / unsigned byte loads of 0x80
    do_req(1'b1, 3'b010, 32'h10, 32'h80AA_BBCC);
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb_sign", 128'(last_rdata), 128'(32'hFFFF_FF80));
    do_req(1'b0, 3'b100, 32'h13, 32'h0);
    chk("lbu_zero", 128'(last_rdata), 128'(32'h0000_0080));

    // misaligned word store, neighbours preserved
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344);
    do_req(1'b1, 3'b010, 32'h24, 32'h5566_7788);
    do_req(1'b1, 3'b010, 32'h21, 32'hDDCC_BBAA);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    chk("sw_mis_lo", 128'(last_rdata), 128'(32'hCCBB_AA44));
    do_req(1'b0, 3'b010, 32'h24, 32'h0);
    chk("sw_mis_hi", 128'(last_rdata), 128'(32'h5566_77DD));

    // misaligned signed half load
    do_req(1'b1, 3'b000, 32'h0B, 32'h0000_0034);
    do_req(1'b1, 3'b000, 32'h0C, 32'h0000_0092);
    do_req(1'b0, 3'b001, 32'h0B, 32'h0);
    chk("lh_mis", 128'(last_rdata), 128'(32'hFFFF_9234));

    // illegal codes
    do_req(1'b0, 3'b011, 32'h40, 32'h1234_5678);
    chk("ill_err", 128'(last_err), 128'(1'b1));
    chk("ill_rdata", 128'(last_rdata), 128'(32'd0));
    do_req(1'b1, 3'b101, 32'h40, 32'h1234_5678);
    chk("ill_store_u", 128'(last_err), 128'(1'b1));

    // reset during the second byte of a split store at 0x31
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h31; req_wdata = 32'h4433_2211;
    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_acc1_we", 128'(mem_we), 128'(1'b1));
    chk("rst_acc1_a", 128'(mem_a), 128'(32'h31));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_no_we", 128'(mem_we), 128'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after", 128'(act_obs), 128'(IDLE_OBS));
    model_mem[8'h31] = 8'h11;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    do_req(1'b0, 3'b010, 32'h30, 32'h0);
    chk("rst_readback", 128'(last_rdata), 128'(32'h0000_1100));

    // address wrap across 2^32
    do_req(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h0A0B_0C0D);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
    chk("wrap_lw", 128'(last_rdata), 128'(32'h0A0B_0C0D));

    // randomized requests
    for (int t = 0; t < 300; t++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      int          g;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6:       f3 = 3'b100;
        7:       f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else                           a = 32'($urandom_range(0, 255));
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom);
    end

    // final memory image
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++)
      chk("mem_image", 128'(dmem[i]), 128'(model_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
